ttt_board_tracker: RTL and testbench
====================================

# ttt_board_tracker

Downstream consumer of the tictactoe core's output stream (xoroout/rowout/colout/win). Keeps a registered 3x3 mirror of the board, counts moves, latches the game result and keeps running X/O/draw tallies. Also drives a row-multiplexed scan of the board for the LED matrix. The tallies survive across games; only reset clears them.

## Interface
- SCANDIV, 4: cycles each scan row stays active (≥1).
- ph1  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- xoroin  in  2  move token from core: 00 none, 01 X, 10 O, 11 illegal.
- rowin  in  2  move row 0–2; 3 illegal.
- colin  in  2  move column 0–2; 3 illegal.
- winin  in  2  core result: 00 none, 01 X wins, 10 O wins, 11 draw.
- clear  in  1  start new game; board and moves cleared, tallies kept.
- board  out  18  cell (r,c) at bits [2(3r+c)+1 : 2(3r+c)], same encoding as xoroin.
- movecount  out  4  moves accepted this game, 0–9.
- result  out  2  latched game result, winin encoding.
- gstate  out  2  00 IDLE, 01 PLAY, 10 OVER.
- xscore, oscore, draws  out  4 each  saturating tallies.
- err  out  1  one-cycle pulse on rejected move.
- scanrow  out  3  one-hot active display row; bit r = row r.
- scancells  out  6  board row r selected by scanrow, col 0 in bits [1:0].

## Operation
- Reset values: board 0, movecount 0, result 00, gstate IDLE, all tallies 0, err 0, scanrow 001, scancells 0, scan counter 0.
- Valid move: xoroin ∈ {01,10}, rowin<3, colin<3.
- Evaluation order in one edge: clear, then move, then winin.
- IDLE / PLAY:
  - Valid move to an empty cell writes the cell and increments movecount. IDLE goes to PLAY.
  - Valid move to an occupied cell does not write and pulses err.
  - xoroin=11, or xoroin≠00 with row or col = 3, does not write and pulses err.
  - xoroin=00 is a no-op, whatever rowin/colin hold.
- PLAY with winin≠00:
  - result ← winin and gstate goes to OVER.
  - Exactly one tally increments: 01→xscore, 10→oscore, 11→draws. Each tally saturates at 15.
  - The win decision uses the board after any same-cycle move write.
- IDLE with winin≠00: ignored, no tally change.
- OVER:
  - Any xoroin≠00 pulses err and leaves the board unchanged.
  - winin is ignored, so the result is never double-counted.
  - State is held until clear.
- clear (any state): board 0, movecount 0, result 00, gstate IDLE.
  - Moves and winin in the same cycle are discarded; err stays 0.
  - Tallies are unchanged.
- movecount never exceeds 9; a 10th valid move can only hit an occupied cell, so it gets err.
- Scan:
  - The counter counts 0..SCANDIV-1. On wrap, scanrow rotates 001→010→100→001.
  - scancells is combinational from board and scanrow, so a new cell value appears on the scan in the same cycle it appears on board.

## Timing
- Move presented before edge N appears on board/movecount after edge N (1-cycle latency).
- err is registered: high for exactly the cycle after edge N, then low unless re-triggered.
- result, gstate and tallies update on the same edge that samples winin.
- Async reset clears all registers immediately, mid-game or mid-scan. The first scan row after release is 001, held SCANDIV cycles.
- Inputs are sampled only at the rising edge of ph1; no input handshake and no backpressure.

## Test plan
- Reset then X(0,0), O(1,1), X(0,1), O(2,2), X(0,2) with winin=01 on the 5th move:
  - board bits[1:0]=01, [3:2]=01, [5:4]=01, [9:8]=10, [17:16]=10.
  - movecount 5, gstate OVER, result 01, xscore 1.
- From PLAY, repeat X(1,1) onto an occupied cell: err pulses for 1 cycle, board and movecount unchanged.
- Present xoroin=11, then X with rowin=3: err pulses on each, board remains 0, gstate IDLE.
- Win/clear sequence:
  - In OVER, send O(2,0) and winin=10: err=1, oscore unchanged.
  - Assert clear together with a valid move: board 0, movecount 0, gstate IDLE, xscore still 1, err 0.
- Win 16 X games back to back using clear: xscore saturates at 15. Then a draw (winin=11): draws=1.
- SCANDIV=4 with X at (2,1):
  - scanrow is 001 for cycles 0–3, 010 for 4–7, 100 for 8–11 with scancells=6'b000100, then 001.
  - Assert reset at cycle 6: scanrow returns to 001 immediately.

Source files
------------

// File: rtl/ttt_board_tracker_if.sv
// ttt_board_tracker_if: move/result stream from the tictactoe core and tracker status outputs
interface ttt_board_tracker_if;
  logic [1:0]  xoroin, rowin, colin, winin;
  logic        clear;
  logic [17:0] board;
  logic [3:0]  movecount, xscore, oscore, draws;
  logic [1:0]  result, gstate;
  logic        err;
  logic [2:0]  scanrow;
  logic [5:0]  scancells;
  modport master (
    output xoroin, rowin, colin, winin, clear,
    input  board, movecount, result, gstate, xscore, oscore, draws, err, scanrow, scancells
  );
  modport slave (
    input  xoroin, rowin, colin, winin, clear,
    output board, movecount, result, gstate, xscore, oscore, draws, err, scanrow, scancells
  );
endinterface

// File: rtl/ttt_board_tracker.sv
// ttt_board_tracker: board mirror, move count, result latch, tallies and LED row scan
module ttt_board_tracker #(
  parameter int SCANDIV = 4
) (
  input logic ph1,
  input logic reset,
  ttt_board_tracker_if.slave bus
);
  localparam int CW = SCANDIV > 1 ? $clog2(SCANDIV) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
  state_t      r_state;
  logic [17:0] r_board;
  logic [3:0]  r_mc, r_x, r_o, r_d;
  logic [1:0]  r_res;
  logic        r_err;
  logic [2:0]  r_row;
  logic [CW-1:0] r_cnt;
  logic [3:0]  w_idx;
  logic [1:0]  w_cell;
  logic        w_valid;
  logic [5:0]  w_cells;
  assign w_idx   = {1'b0, bus.rowin, 1'b0} + {2'b00, bus.rowin} + {2'b00, bus.colin};
  assign w_cell  = r_board[{w_idx, 1'b0} +: 2];
  assign w_valid = (bus.xoroin == 2'b01 || bus.xoroin == 2'b10) && bus.rowin != 2'd3 && bus.colin != 2'd3;
  always_comb begin
    w_cells = r_row[0] ? r_board[5:0] : r_row[1] ? r_board[11:6] : r_board[17:12];
  end
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_board <= '0;
      r_mc    <= '0;
      r_res   <= '0;
      r_x     <= '0;
      r_o     <= '0;
      r_d     <= '0;
      r_err   <= 1'b0;
      r_row   <= 3'b001;
      r_cnt   <= '0;
    end else begin
      if (r_cnt == CW'(SCANDIV - 1)) begin
        r_cnt <= '0;
        r_row <= {r_row[1:0], r_row[2]};
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_err <= 1'b0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_board <= '0;
        r_mc    <= '0;
        r_res   <= '0;
      end else if (r_state == OVER) begin
        r_err <= bus.xoroin != 2'b00;
      end else begin
        if (bus.xoroin != 2'b00) begin
          if (w_valid && w_cell == 2'b00) begin
            r_board[{w_idx, 1'b0} +: 2] <= bus.xoroin;
            r_mc <= r_mc + 4'd1;
            if (r_state == IDLE) r_state <= PLAY;
          end else begin
            r_err <= 1'b1;
          end
        end
        // win is only honoured once a game is under way; IDLE results are stale
        if (r_state == PLAY && bus.winin != 2'b00) begin
          r_res   <= bus.winin;
          r_state <= OVER;
          if (bus.winin == 2'b01 && r_x != 4'hf) r_x <= r_x + 4'd1;
          if (bus.winin == 2'b10 && r_o != 4'hf) r_o <= r_o + 4'd1;
          if (bus.winin == 2'b11 && r_d != 4'hf) r_d <= r_d + 4'd1;
        end
      end
    end
  end
  assign bus.board     = r_board;
  assign bus.movecount = r_mc;
  assign bus.result    = r_res;
  assign bus.gstate    = r_state;
  assign bus.xscore    = r_x;
  assign bus.oscore    = r_o;
  assign bus.draws     = r_d;
  assign bus.err       = r_err;
  assign bus.scanrow   = r_row;
  assign bus.scancells = w_cells;
endmodule

// File: tb/tb_ttt_board_tracker.sv
// tb_ttt_board_tracker: table-driven move/result vectors plus scan, fill and saturation sequences
module tb_ttt_board_tracker;
  logic ph1 = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  ttt_board_tracker_if bus ();
  ttt_board_tracker #(.SCANDIV(4)) dut (.ph1(ph1), .reset(reset), .bus(bus));
  always #5 ph1 = ~ph1;
  typedef struct {
    logic [1:0]  xo, row, col, win;
    logic        clr;
    logic [17:0] bd;
    logic [3:0]  mc;
    logic [1:0]  res, gs;
    logic        er;
    logic [3:0]  xs, os, ds;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask
  task automatic mv(input logic [1:0] xo, row, col, win, input logic clr);
    bus.xoroin = xo;
    bus.rowin  = row;
    bus.colin  = col;
    bus.winin  = win;
    bus.clear  = clr;
    @(posedge ph1);
    @(negedge ph1);
    bus.xoroin = 2'b00;
    bus.rowin  = 2'd0;
    bus.colin  = 2'd0;
    bus.winin  = 2'b00;
    bus.clear  = 1'b0;
  endtask
  initial begin
    logic [17:0] exp_bd;
    logic [1:0] tok;
    v[0]  = '{2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 18'h00001, 4'd1, 2'd0, 2'd1, 1'b0, 4'd0, 4'd0, 4'd0};
    v[1]  = '{2'd2, 2'd1, 2'd1, 2'd0, 1'b0, 18'h00201, 4'd2, 2'd0, 2'd1, 1'b0, 4'd0, 4'd0, 4'd0};
    v[2]  = '{2'd1, 2'd0, 2'd1, 2'd0, 1'b0, 18'h00205, 4'd3, 2'd0, 2'd1, 1'b0, 4'd0, 4'd0, 4'd0};
    v[3]  = '{2'd1, 2'd1, 2'd1, 2'd0, 1'b0, 18'h00205, 4'd3, 2'd0, 2'd1, 1'b1, 4'd0, 4'd0, 4'd0};
    v[4]  = '{2'd0, 2'd3, 2'd3, 2'd0, 1'b0, 18'h00205, 4'd3, 2'd0, 2'd1, 1'b0, 4'd0, 4'd0, 4'd0};
    v[5]  = '{2'd2, 2'd2, 2'd2, 2'd0, 1'b0, 18'h20205, 4'd4, 2'd0, 2'd1, 1'b0, 4'd0, 4'd0, 4'd0};
    v[6]  = '{2'd1, 2'd0, 2'd2, 2'd1, 1'b0, 18'h20215, 4'd5, 2'd1, 2'd2, 1'b0, 4'd1, 4'd0, 4'd0};
    v[7]  = '{2'd2, 2'd2, 2'd0, 2'd2, 1'b0, 18'h20215, 4'd5, 2'd1, 2'd2, 1'b1, 4'd1, 4'd0, 4'd0};
    v[8]  = '{2'd1, 2'd1, 2'd1, 2'd1, 1'b1, 18'h00000, 4'd0, 2'd0, 2'd0, 1'b0, 4'd1, 4'd0, 4'd0};
    v[9]  = '{2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 18'h00000, 4'd0, 2'd0, 2'd0, 1'b1, 4'd1, 4'd0, 4'd0};
    v[10] = '{2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 18'h00000, 4'd0, 2'd0, 2'd0, 1'b1, 4'd1, 4'd0, 4'd0};
    v[11] = '{2'd0, 2'd0, 2'd0, 2'd2, 1'b0, 18'h00000, 4'd0, 2'd0, 2'd0, 1'b0, 4'd1, 4'd0, 4'd0};
    v[12] = '{2'd1, 2'd1, 2'd0, 2'd1, 1'b0, 18'h00040, 4'd1, 2'd0, 2'd1, 1'b0, 4'd1, 4'd0, 4'd0};
    v[13] = '{2'd1, 2'd0, 2'd0, 2'd3, 1'b0, 18'h00041, 4'd2, 2'd3, 2'd2, 1'b0, 4'd1, 4'd0, 4'd1};
    v[14] = '{2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 18'h00000, 4'd0, 2'd0, 2'd0, 1'b0, 4'd1, 4'd0, 4'd1};
    bus.xoroin = 2'b00;
    bus.rowin  = 2'd0;
    bus.colin  = 2'd0;
    bus.winin  = 2'b00;
    bus.clear  = 1'b0;
    @(negedge ph1);
    @(negedge ph1);
    chk("rst_board", bus.board, 0);
    chk("rst_mc", bus.movecount, 0);
    chk("rst_res", bus.result, 0);
    chk("rst_gs", bus.gstate, 0);
    chk("rst_tally", {bus.xscore, bus.oscore, bus.draws}, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_scan", {bus.scanrow, bus.scancells}, {3'b001, 6'b0});
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mv(v[i].xo, v[i].row, v[i].col, v[i].win, v[i].clr);
      chk($sformatf("v%0d_board", i), bus.board, v[i].bd);
      chk($sformatf("v%0d_mc", i), bus.movecount, v[i].mc);
      chk($sformatf("v%0d_res", i), bus.result, v[i].res);
      chk($sformatf("v%0d_gs", i), bus.gstate, v[i].gs);
      chk($sformatf("v%0d_err", i), bus.err, v[i].er);
      chk($sformatf("v%0d_tally", i), {bus.xscore, bus.oscore, bus.draws}, {v[i].xs, v[i].os, v[i].ds});
    end
    exp_bd = '0;
    for (int i = 0; i < 9; i++) begin
      tok = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_bd[2*i +: 2] = tok;
      mv(tok, 2'(i / 3), 2'(i % 3), 2'b00, 1'b0);
    end
    chk("full_board", bus.board, exp_bd);
    chk("full_mc", bus.movecount, 9);
    chk("full_gs", bus.gstate, 1);
    mv(2'b01, 2'd0, 2'd0, 2'b00, 1'b0);
    chk("tenth_err", bus.err, 1);
    chk("tenth_mc", bus.movecount, 9);
    chk("tenth_board", bus.board, exp_bd);
    for (int g = 0; g < 16; g++) begin
      mv(2'b00, 2'd0, 2'd0, 2'b00, 1'b1);
      mv(2'b01, 2'd0, 2'd0, 2'b00, 1'b0);
      mv(2'b01, 2'd0, 2'd1, 2'b01, 1'b0);
    end
    chk("sat_x", bus.xscore, 15);
    chk("sat_gs", bus.gstate, 2);
    chk("sat_res", bus.result, 1);
    chk("sat_o", bus.oscore, 0);
    mv(2'b00, 2'd0, 2'd0, 2'b00, 1'b1);
    mv(2'b01, 2'd0, 2'd0, 2'b00, 1'b0);
    mv(2'b10, 2'd1, 2'd1, 2'b11, 1'b0);
    chk("draw_d", bus.draws, 2);
    chk("draw_x", bus.xscore, 15);
    chk("draw_res", bus.result, 3);
    reset = 1'b1;
    @(negedge ph1);
    reset = 1'b0;
    bus.xoroin = 2'b01;
    bus.rowin  = 2'd2;
    bus.colin  = 2'd1;
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("scan%0d_row", k), bus.scanrow, 3'b001 << ((k / 4) % 3));
      chk($sformatf("scan%0d_cells", k), bus.scancells, (k >= 8 && k < 12) ? 6'b000100 : 6'b0);
      @(posedge ph1);
      @(negedge ph1);
      bus.xoroin = 2'b00;
      bus.rowin  = 2'd0;
      bus.colin  = 2'd0;
    end
    reset = 1'b1;
    @(negedge ph1);
    reset = 1'b0;
    repeat (6) begin
      @(posedge ph1);
      @(negedge ph1);
    end
    chk("mid_row", bus.scanrow, 3'b010);
    #2 reset = 1'b1;
    #1;
    chk("async_row", bus.scanrow, 3'b001);
    chk("async_board", bus.board, 0);
    @(negedge ph1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rel%0d_row", k), bus.scanrow, k < 4 ? 3'b001 : 3'b010);
      @(posedge ph1);
      @(negedge ph1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
